// File: rtl/apb_master_if.sv
// rtl/apb_master_if.sv - command/response handshake and APB requester signal bundle
interface apb_master_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              rsp_timeout;

   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      input  PRDATA, PREADY, PSLVERR,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      output PRDATA, PREADY, PSLVERR,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );
endinterface

// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-outstanding APB requester driven by a command/response handshake
module apb_master #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic         PCLK,
   input  logic         PRSTn,
   apb_master_if.master bus
);
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic             timeout_hit;

   // Fires on the ACCESS cycle whose stall would bring the counter to TIMEOUT
   assign timeout_hit = (TIMEOUT != 0) && ((32'(wait_cnt) + 32'd1) >= 32'(TIMEOUT));

   always_ff @(posedge PCLK or negedge PRSTn) begin
      if (!PRSTn) begin
         state           <= IDLE;
         wait_cnt        <= '0;
         bus.cmd_ready   <= 1'b0;
         bus.rsp_valid   <= 1'b0;
         bus.rsp_rdata   <= {DATA_W{1'b0}};
         bus.rsp_err     <= 1'b0;
         bus.rsp_timeout <= 1'b0;
         bus.PSEL        <= 1'b0;
         bus.PENABLE     <= 1'b0;
         bus.PWRITE      <= 1'b0;
         bus.PADDR       <= {ADDR_W{1'b0}};
         bus.PWDATA      <= {DATA_W{1'b0}};
      end else begin
         case (state)
            IDLE: begin
               if (bus.cmd_ready && bus.cmd_valid) begin
                  bus.cmd_ready <= 1'b0;
                  bus.PSEL      <= 1'b1;
                  bus.PENABLE   <= 1'b0;
                  bus.PWRITE    <= bus.cmd_write;
                  bus.PADDR     <= bus.cmd_addr;
                  // Reads leave the previous write data on the bus
                  if (bus.cmd_write) begin
                     bus.PWDATA <= bus.cmd_wdata;
                  end
                  state <= SETUP;
               end else begin
                  bus.cmd_ready <= 1'b1;
               end
            end
            SETUP: begin
               bus.PENABLE <= 1'b1;
               wait_cnt    <= '0;
               state       <= ACCESS;
            end
            ACCESS: begin
               if (bus.PREADY) begin
                  bus.PSEL        <= 1'b0;
                  bus.PENABLE     <= 1'b0;
                  bus.rsp_valid   <= 1'b1;
                  bus.rsp_err     <= bus.PSLVERR;
                  bus.rsp_timeout <= 1'b0;
                  bus.rsp_rdata   <= (!bus.PWRITE && !bus.PSLVERR) ? bus.PRDATA : {DATA_W{1'b0}};
                  state           <= RESP;
               end else if (timeout_hit) begin
                  bus.PSEL        <= 1'b0;
                  bus.PENABLE     <= 1'b0;
                  bus.rsp_valid   <= 1'b1;
                  bus.rsp_err     <= 1'b1;
                  bus.rsp_timeout <= 1'b1;
                  bus.rsp_rdata   <= {DATA_W{1'b0}};
                  state           <= RESP;
               end else if (wait_cnt != {CNT_W{1'b1}}) begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            RESP: begin
               // cmd_ready rises only after the response leaves, so no back-to-back accept
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  bus.cmd_ready <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - directed plus randomized check of apb_master against a transaction-level model
module tb_apb_master;
   localparam int TIMEOUT = 16;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail = 0;
   logic [31:0] exp_pwdata = '0;

   apb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
      .PCLK  (clk),
      .PRSTn (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] ctl();
      return {bus.PSEL, bus.PENABLE, bus.cmd_ready, bus.rsp_valid};
   endfunction

   // One complete transfer; the slave answers on ACCESS cycle wait_n+1 unless the timeout wins
   task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int wait_n, input logic err,
                           input int hold);
      logic        to;
      int          acc_n;
      logic        e_err;
      logic [31:0] e_rdata;
      int          last;
      logic [3:0]  e_ctl;
      to      = (TIMEOUT != 0) && (wait_n >= TIMEOUT);
      acc_n   = to ? TIMEOUT : wait_n + 1;
      e_err   = to | err;
      e_rdata = (wr || e_err) ? 32'd0 : rdata;
      if (wr) exp_pwdata = wdata;
      last    = 2 + acc_n + hold;

      check("idle cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wdata;
      bus.rsp_ready = 1'b0;
      for (int k = 1; k <= last; k++) begin
         @(posedge clk); #1;
         // cmd_valid stays high with junk fields; none of it may leak into the transfer
         bus.cmd_write = 1'($urandom);
         bus.cmd_addr  = $urandom;
         bus.cmd_wdata = $urandom;
         if (k == 1)            e_ctl = 4'b1000;
         else if (k <= 1 + acc_n) e_ctl = 4'b1100;
         else                   e_ctl = 4'b0001;
         check($sformatf("ctl k=%0d", k), {60'd0, ctl()}, {60'd0, e_ctl});
         if (e_ctl[3]) begin
            check($sformatf("PADDR k=%0d", k), {32'd0, bus.PADDR}, {32'd0, addr});
            check($sformatf("PWRITE k=%0d", k), {63'd0, bus.PWRITE}, {63'd0, wr});
            check($sformatf("PWDATA k=%0d", k), {32'd0, bus.PWDATA}, {32'd0, exp_pwdata});
         end
         if (e_ctl[0]) begin
            check($sformatf("rsp err/to k=%0d", k), {62'd0, bus.rsp_err, bus.rsp_timeout},
                  {62'd0, e_err, to});
            check($sformatf("rsp_rdata k=%0d", k), {32'd0, bus.rsp_rdata}, {32'd0, e_rdata});
         end
         if (e_ctl == 4'b1100) begin
            bus.PREADY  = !to && (k == 1 + acc_n);
            bus.PRDATA  = (k == 1 + acc_n) ? rdata : $urandom;
            bus.PSLVERR = (k == 1 + acc_n) ? err : 1'($urandom);
         end else begin
            bus.PREADY  = 1'($urandom);
            bus.PRDATA  = $urandom;
            bus.PSLVERR = 1'($urandom);
         end
         bus.rsp_ready = (k == last);
      end
      @(posedge clk); #1;
      check("after rsp", {60'd0, ctl()}, {60'd0, 4'b0010});
      bus.rsp_ready = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.PREADY    = 1'b0;
      bus.PSLVERR   = 1'b0;
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.rsp_ready = 1'b0;
      bus.PRDATA    = '0;
      bus.PREADY    = 1'b0;
      bus.PSLVERR   = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("reset ctl", {60'd0, ctl()}, 64'd0);
      check("reset addr/data", {bus.PADDR, bus.PWDATA}, 64'd0);
      check("reset rsp", {29'd0, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout, bus.PWRITE}, 64'd0);
      rst_n = 1'b1;
      #1;
      check("cmd_ready before edge", {63'd0, bus.cmd_ready}, 64'd0);
      @(posedge clk); #1;
      check("cmd_ready first edge", {63'd0, bus.cmd_ready}, 64'd1);

      run_xfer(1'b1, 32'h0C, 32'h118, 32'h0, 0, 1'b0, 0);
      run_xfer(1'b0, 32'h08, 32'h0, 32'h06, 3, 1'b0, 0);
      run_xfer(1'b0, 32'h04, 32'h0, 32'h43, 0, 1'b1, 0);
      run_xfer(1'b0, 32'h10, 32'h0, 32'h55, TIMEOUT + 4, 1'b0, 0);
      run_xfer(1'b1, 32'h20, 32'hABCD, 32'h0, 1, 1'b0, 5);
      run_xfer(1'b0, 32'h24, 32'h0, 32'h77, TIMEOUT - 1, 1'b0, 1);

      // Reset in the middle of ACCESS aborts silently
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 32'h30;
      bus.cmd_wdata = 32'h1234;
      bus.PREADY    = 1'b0;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("pre-reset access", {60'd0, ctl()}, {60'd0, 4'b1100});
      #2 rst_n = 1'b0;
      #1;
      check("async reset ctl", {60'd0, ctl()}, 64'd0);
      check("async reset addr/data", {bus.PADDR, bus.PWDATA}, 64'd0);
      @(posedge clk); #1;
      check("in reset rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
      rst_n = 1'b1;
      exp_pwdata = '0;
      @(posedge clk); #1;
      check("post reset ctl", {60'd0, ctl()}, {60'd0, 4'b0010});
      run_xfer(1'b0, 32'h34, 32'h0, 32'hCAFE, 2, 1'b0, 0);

      for (int i = 0; i < 30; i++) begin
         run_xfer(1'($urandom), $urandom, $urandom, $urandom, int'($urandom_range(0, TIMEOUT + 3)),
                  ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
